// File: rtl/ro_puf_eval_ctrl.sv
// Ring-oscillator PUF evaluation sequencer: walks every oscillator pair through
// settle / clear / count / hold / compare and assembles one response bit per pair.
module ro_puf_eval_ctrl #(
  parameter  int NUM_PAIRS  = 4,
  parameter  int CNT_SIZE   = 32,
  parameter  int WINDOW     = 16,
  parameter  int SETTLE_CYC = 2,
  parameter  int HOLD_CYC   = 2,
  localparam int SEL_W      = (NUM_PAIRS > 2) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_SIZE-1:0]  count1,
  input  logic [CNT_SIZE-1:0]  count2,
  output logic [SEL_W-1:0]     pair_sel,
  output logic                 counter_clear,
  output logic                 counter_enable,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PAIRS-1:0] response,
  output logic                 tie_flag
);

  localparam int MAXC = (WINDOW > SETTLE_CYC) ? ((WINDOW > HOLD_CYC) ? WINDOW : HOLD_CYC)
                                              : ((SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_COUNT   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_COMPARE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic          last_pair_s;
  logic          accept_s;
  logic          busy_nxt_s;
  logic          clear_nxt_s;
  logic          enable_nxt_s;
  logic          done_nxt_s;

  assign last_pair_s = (pair_sel == SEL_W'(NUM_PAIRS - 1));
  assign accept_s    = (state_r == ST_IDLE) && start && !abort;

  // State register and in-state cycle counter (restarts on every state change)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Next-state logic; abort overrides everything and is harmless in IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    if (start) state_nxt_s = ST_SETTLE; else state_nxt_s = ST_IDLE;
        ST_SETTLE:  if (cnt_r == CW'(SETTLE_CYC - 1)) state_nxt_s = ST_CLEAR; else state_nxt_s = ST_SETTLE;
        ST_CLEAR:   state_nxt_s = ST_COUNT;
        ST_COUNT:   if (cnt_r == CW'(WINDOW - 1)) state_nxt_s = ST_HOLD; else state_nxt_s = ST_COUNT;
        ST_HOLD:    if (cnt_r == CW'(HOLD_CYC - 1)) state_nxt_s = ST_COMPARE; else state_nxt_s = ST_HOLD;
        ST_COMPARE: if (last_pair_s) state_nxt_s = ST_DONE; else state_nxt_s = ST_SETTLE;
        ST_DONE:    state_nxt_s = ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Moore output decode from the next state so the registered outputs line up with the state
  always_comb begin
    busy_nxt_s   = 1'b0;
    clear_nxt_s  = 1'b0;
    enable_nxt_s = 1'b0;
    done_nxt_s   = 1'b0;
    case (state_nxt_s)
      ST_IDLE:  busy_nxt_s = 1'b0;
      ST_CLEAR: begin busy_nxt_s = 1'b1; clear_nxt_s  = 1'b1; end
      ST_COUNT: begin busy_nxt_s = 1'b1; enable_nxt_s = 1'b1; end
      ST_DONE:  begin busy_nxt_s = 1'b1; done_nxt_s   = 1'b1; end
      default:  busy_nxt_s = 1'b1;
    endcase
  end

  // Output registers plus pair index and response accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= 1'b0;
      counter_clear  <= 1'b0;
      counter_enable <= 1'b0;
      done           <= 1'b0;
      pair_sel       <= {SEL_W{1'b0}};
      response       <= {NUM_PAIRS{1'b0}};
      tie_flag       <= 1'b0;
    end else begin
      busy           <= busy_nxt_s;
      counter_clear  <= clear_nxt_s;
      counter_enable <= enable_nxt_s;
      done           <= done_nxt_s;
      if ((abort && (state_r != ST_IDLE)) || accept_s) begin
        pair_sel <= {SEL_W{1'b0}};
        response <= {NUM_PAIRS{1'b0}};
        tie_flag <= 1'b0;
      end else if (state_r == ST_COMPARE) begin
        // ties resolve to 0 but are remembered for the consumer
        response[pair_sel] <= (count1 > count2);
        tie_flag           <= tie_flag | (count1 == count2);
        if (!last_pair_s) begin
          pair_sel <= pair_sel + SEL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ro_puf_eval_ctrl.sv
// Self-checking bench for ro_puf_eval_ctrl: directed and random evaluations compared
// against a cycle-offset schedule model and an arithmetic response model.
module tb_ro_puf_eval_ctrl;

  localparam int NP  = 4;
  localparam int CS  = 32;
  localparam int WIN = 16;
  localparam int SC  = 2;
  localparam int HC  = 2;
  localparam int SW  = 2;
  localparam int P   = SC + 1 + WIN + HC + 1;
  localparam int TOT = NP * P;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CS-1:0] count1;
  logic [CS-1:0] count2;
  logic [SW-1:0] pair_sel;
  logic          counter_clear;
  logic          counter_enable;
  logic          busy;
  logic          done;
  logic [NP-1:0] response;
  logic          tie_flag;

  logic [CS-1:0] c1_tab [NP];
  logic [CS-1:0] c2_tab [NP];

  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  en_cnt;
  time done_t [$];

  ro_puf_eval_ctrl #(
    .NUM_PAIRS(NP), .CNT_SIZE(CS), .WINDOW(WIN), .SETTLE_CYC(SC), .HOLD_CYC(HC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .count1(count1), .count2(count2), .pair_sel(pair_sel),
    .counter_clear(counter_clear), .counter_enable(counter_enable),
    .busy(busy), .done(done), .response(response), .tie_flag(tie_flag)
  );

  // external mux: the selected pair's counter values
  assign count1 = c1_tab[pair_sel];
  assign count2 = c2_tab[pair_sel];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [NP-1:0] exp_resp(input int c);
    logic [NP-1:0] r = '0;
    for (int p = 0; p < NP; p++)
      if (p < c / P) r[p] = (c1_tab[p] > c2_tab[p]);
    return r;
  endfunction

  function automatic logic exp_tie(input int c);
    logic t = 1'b0;
    for (int p = 0; p < NP; p++)
      if (p < c / P && c1_tab[p] == c2_tab[p]) t = 1'b1;
    return t;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({pair_sel, counter_clear, counter_enable, busy, done, response, tie_flag});
  endfunction

  // c = number of clock edges elapsed after the edge that accepted start
  task automatic step_check(input int c);
    int p = (c < TOT) ? c / P : NP - 1;
    int o = c % P;
    chk("busy",     64'(busy), 64'(1));
    chk("done",     64'(done), 64'(c == TOT));
    chk("pair_sel", 64'(pair_sel), 64'(p));
    chk("clear",    64'(counter_clear), 64'(c < TOT && o == SC));
    chk("enable",   64'(counter_enable), 64'(c < TOT && o > SC && o <= SC + WIN));
    chk("overlap",  64'(counter_clear & counter_enable), 64'(0));
    chk("response", 64'(response), 64'(exp_resp(c)));
    chk("tie",      64'(tie_flag), 64'(exp_tie(c)));
    if (counter_enable) en_cnt++;
    if (done) done_t.push_back($time);
  endtask

  task automatic run_eval(input bit hold);
    en_cnt = 0;
    start = 1'b1;
    chk("idle_busy", 64'(busy), 64'(0));
    for (int c = 0; c <= TOT; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) start = 1'b0;
      step_check(c);
    end
    chk("en_total", 64'(en_cnt), 64'(NP * WIN));
    @(negedge clk);
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_done", 64'(done), 64'(0));
    chk("held_resp", 64'(response), 64'(exp_resp(TOT)));
    chk("held_tie",  64'(tie_flag), 64'(exp_tie(TOT)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    for (int p = 0; p < NP; p++) begin c1_tab[p] = '0; c2_tab[p] = '0; end
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 64'(0));

    // T1: all pairs 100 vs 50
    for (int p = 0; p < NP; p++) begin c1_tab[p] = 32'd100; c2_tab[p] = 32'd50; end
    done_t.delete();
    run_eval(1'b0);
    chk("t1_resp", 64'(response), 64'(4'b1111));
    chk("t1_ndone", 64'(done_t.size()), 64'(1));

    // T2: alternating winners
    c1_tab[0] = 32'd200; c2_tab[0] = 32'd10;
    c1_tab[1] = 32'd10;  c2_tab[1] = 32'd200;
    c1_tab[2] = 32'd300; c2_tab[2] = 32'd299;
    c1_tab[3] = 32'd299; c2_tab[3] = 32'd300;
    run_eval(1'b0);
    chk("t2_resp", 64'(response), 64'(4'b0101));

    // T3: tie on pair 2
    for (int p = 0; p < NP; p++) begin c1_tab[p] = 32'd90; c2_tab[p] = 32'd40; end
    c1_tab[2] = 32'd77; c2_tab[2] = 32'd77;
    run_eval(1'b0);
    chk("t3_resp", 64'(response), 64'(4'b1011));
    chk("t3_tie",  64'(tie_flag), 64'(1));

    // unsigned extremes
    c1_tab[0] = 32'hFFFF_FFFF; c2_tab[0] = 32'h0;
    c1_tab[1] = 32'h0;         c2_tab[1] = 32'hFFFF_FFFF;
    c1_tab[2] = 32'h8000_0000; c2_tab[2] = 32'h7FFF_FFFF;
    c1_tab[3] = 32'h0;         c2_tab[3] = 32'h0;
    run_eval(1'b0);

    // random counts with occasional forced ties
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < NP; p++) begin
        c1_tab[p] = $urandom;
        c2_tab[p] = ($urandom_range(0, 3) == 0) ? c1_tab[p] : $urandom;
      end
      run_eval(1'b0);
    end

    // T4: start held high -> back-to-back evaluations
    for (int p = 0; p < NP; p++) begin c1_tab[p] = $urandom; c2_tab[p] = $urandom; end
    done_t.delete();
    run_eval(1'b1);
    run_eval(1'b0);
    chk("t4_ndone", 64'(done_t.size()), 64'(2));
    if (done_t.size() == 2) chk("t4_gap", 64'(done_t[1] - done_t[0]), 64'(900));

    // T5: abort during COUNT of pair 1
    for (int p = 0; p < NP; p++) begin c1_tab[p] = 32'd100; c2_tab[p] = 32'd50; end
    done_t.delete();
    en_cnt = 0;
    start = 1'b1;
    for (int c = 0; c <= P + SC + 6; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      step_check(c);
    end
    abort = 1'b1;
    @(negedge clk);
    chk("t5_abort_outs", all_outs(), 64'(0));
    abort = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_stay_idle", all_outs(), 64'(0));
    end
    chk("t5_no_done", 64'(done_t.size()), 64'(0));
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("t5_abort_blocks_start", 64'(busy), 64'(0));
    abort = 1'b0;
    run_eval(1'b0);
    chk("t5_clean_resp", 64'(response), 64'(4'b1111));

    // T6: asynchronous reset mid-COUNT
    c1_tab[0] = 32'd5; c2_tab[0] = 32'd9;
    c1_tab[1] = 32'd9; c2_tab[1] = 32'd5;
    c1_tab[2] = 32'd5; c2_tab[2] = 32'd9;
    c1_tab[3] = 32'd9; c2_tab[3] = 32'd5;
    en_cnt = 0;
    start = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      step_check(c);
    end
    #2 rst = 1'b1;
    #1 chk("t6_async_outs", all_outs(), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_stay_idle", all_outs(), 64'(0));
    end
    run_eval(1'b0);
    chk("t6_clean_resp", 64'(response), 64'(4'b1010));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
